// File: rtl/gc_joybus_pkg.sv
// rtl/gc_joybus_pkg.sv - shared state encoding and Joybus timing/frame constants
package gc_joybus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        WAIT_EDGE,
        COMPLETE
    } rx_state_t;

    // Tick counts for a 50 MHz PCLK: sample 2 us into the bit, abort after 10 us of silence
    localparam int GC_SAMPLE_TICKS  = 100;
    localparam int GC_TIMEOUT_TICKS = 500;

    localparam int GC_STATUS_BITS = 64;
    localparam int GC_ID_BITS     = 24;

endpackage

// File: rtl/gc_joybus_rx_if.sv
// rtl/gc_joybus_rx_if.sv - frame hand-over channel from the receiver to its consumer
interface gc_joybus_rx_if #(
    parameter int MAX_BITS = 64
) ();

    logic [MAX_BITS-1:0] frame_data;
    logic [7:0]          frame_bits;
    logic                frame_valid;
    logic                frame_ready;

    modport master (
        output frame_data,
        output frame_bits,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_bits,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/gc_line_sync.sv
// rtl/gc_line_sync.sv - synchroniser chain and falling-edge detector for the Joybus line
module gc_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Flops reset to the idle-high level of the open-drain line so release gives no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = hist_q & ~level;

endmodule

// File: rtl/gc_joybus_rx.sv
// rtl/gc_joybus_rx.sv - Joybus response-frame receiver with programmable length and sticky errors
module gc_joybus_rx
    import gc_joybus_pkg::*;
#(
    parameter int MAX_BITS      = 64,
    parameter int SAMPLE_TICKS  = 200,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    input  logic                  data_in,
    input  logic                  rx_enable,
    input  logic [7:0]            expect_bits,
    input  logic                  err_clear,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_stop,
    output logic                  err_overrun,
    gc_joybus_rx_if.master        frame
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int BIT_W = $clog2(MAX_BITS + 2);

    localparam logic [CNT_W-1:0] SAMPLE_T  = CNT_W'(SAMPLE_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT_T = CNT_W'(TIMEOUT_TICKS);

    rx_state_t             state;
    logic [CNT_W-1:0]      tick;
    logic [BIT_W-1:0]      bitcnt;
    logic [BIT_W-1:0]      eb;
    logic [MAX_BITS-1:0]   shift;
    logic                  level;
    logic                  fall;

    gc_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .data_in (data_in),
        .level   (level),
        .fall    (fall)
    );

    // Zero means "the largest frame", and anything over the register width is clamped to it
    function automatic logic [BIT_W-1:0] clamp_eb(input logic [7:0] e);
        if (e == 8'd0 || int'(e) > MAX_BITS)
            return BIT_W'(MAX_BITS);
        else
            return BIT_W'(e);
    endfunction

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state             <= IDLE;
            tick              <= '0;
            bitcnt            <= '0;
            eb                <= '0;
            shift             <= '0;
            busy              <= 1'b0;
            err_short         <= 1'b0;
            err_stop          <= 1'b0;
            err_overrun       <= 1'b0;
            frame.frame_data  <= '0;
            frame.frame_bits  <= '0;
            frame.frame_valid <= 1'b0;
        end else begin
            // Clears come first so a same-cycle set further down wins
            if (err_clear) begin
                err_short   <= 1'b0;
                err_stop    <= 1'b0;
                err_overrun <= 1'b0;
            end

            if (frame.frame_valid && frame.frame_ready)
                frame.frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall && rx_enable) begin
                        state  <= SAMPLE;
                        busy   <= 1'b1;
                        tick   <= CNT_W'(1);
                        bitcnt <= '0;
                        shift  <= '0;
                        eb     <= clamp_eb(expect_bits);
                    end
                end

                SAMPLE: begin
                    if (!rx_enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick == SAMPLE_T) begin
                        tick <= '0;
                        if (bitcnt < eb) begin
                            shift  <= {shift[MAX_BITS-2:0], level};
                            bitcnt <= bitcnt + BIT_W'(1);
                            state  <= WAIT_EDGE;
                        end else begin
                            if (!level)
                                err_stop <= 1'b1;
                            state <= COMPLETE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick <= tick + CNT_W'(1);
                    end
                end

                WAIT_EDGE: begin
                    if (!rx_enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fall) begin
                        state <= SAMPLE;
                        tick  <= CNT_W'(1);
                    end else if (tick == TIMEOUT_T) begin
                        err_short <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        tick <= tick + CNT_W'(1);
                    end
                end

                COMPLETE: begin
                    // A frame still awaiting pickup is never overwritten; the new one is lost
                    if (!frame.frame_valid || frame.frame_ready) begin
                        frame.frame_data  <= shift;
                        frame.frame_bits  <= 8'(eb);
                        frame.frame_valid <= 1'b1;
                    end else begin
                        err_overrun <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
